mem_loader: RTL and testbench

- Byte-stream program loader that writes 26-bit LVDC words into backplane memory at run time, replacing hex preload of the memory array.
- Accepts framed bytes from a host link over a valid/ready handshake and issues single-word memory writes.
- Holds the CPU halted while a load is in progress.
- Reports completion, checksum errors and inter-byte timeouts.

---
 rtl/mem_loader.sv | 186 ++++++++++++++++++
 tb/tb_mem_loader.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// mem_loader: byte-stream program loader for the LVDC backplane memory.
//
// Receives framed bytes from a host link and writes each 26-bit word into
// memory with a single-word write handshake. The CPU is held halted for the
// whole load. Completion, checksum errors, inter-byte timeouts and writes
// overrun by pending host bytes are reported through done/error/err_code.
//
// Frame: SYNC, ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, N x 4 data bytes
// (little-endian), CSUM. CSUM is the mod-256 sum of every byte after SYNC.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   rx_data/valid/ready   host byte stream (transfer when valid && ready)
//   mem_addr/wdata/we     memory write request, held until mem_ready
//   mem_ready             memory accepted the write this cycle
//   cpu_halt              CPU must stall while a frame is in progress
//   done, error, err_code result of the last frame
//                         (err_code 1 = checksum, 2 = timeout, 3 = overlap)
module mem_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         ADDR_W    = 15,
  parameter int         DATA_W    = 26,
  parameter int         TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              cpu_halt,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  typedef enum logic [2:0] {
    IDLE, A_LO, A_HI, C_LO, C_HI, DATA, WRITE, CSUM
  } state_t;

  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERLAP = 2'd3;

  // Host bytes pending this long while a write is stuck abort the frame.
  localparam logic [8:0] OVERLAP_LIMIT = 9'd256;

  state_t      state;
  logic [7:0]  csum;
  logic [7:0]  cnt_lo;
  logic [15:0] words_left;
  logic [1:0]  byte_idx;
  logic [23:0] asm_bytes;   // first three bytes of the word being assembled
  logic [31:0] to_cnt;
  logic [8:0]  ov_cnt;

  logic take;
  logic timed;
  logic to_hit;

  // NOTE: every signal written here gets a value on every path, so this stays
  // pure combinational logic and no latch is inferred.
  always_comb begin
    take   = rx_valid && rx_ready;
    timed  = (state != IDLE) && (state != WRITE);
    to_hit = (TIMEOUT != 0) && timed && !take && (to_cnt == 32'(TIMEOUT - 1));
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values; the defaults at the top of the else-branch
  // are overridden by later assignments in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rx_ready   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      cpu_halt   <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= 2'd0;
      csum       <= 8'd0;
      cnt_lo     <= 8'd0;
      words_left <= 16'd0;
      byte_idx   <= 2'd0;
      asm_bytes  <= 24'd0;
      to_cnt     <= 32'd0;
      ov_cnt     <= 9'd0;
    end else begin
      // Ready everywhere except while a write is outstanding.
      rx_ready <= 1'b1;

      // Inter-byte gap counter, restarted by every accepted byte.
      if (!timed || take) to_cnt <= 32'd0;
      else                to_cnt <= to_cnt + 32'd1;

      if (to_hit) begin
        state    <= IDLE;
        error    <= 1'b1;
        err_code <= ERR_TIMEOUT;
        cpu_halt <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (take && rx_data == SYNC_BYTE) begin
              state    <= A_LO;
              csum     <= 8'd0;
              done     <= 1'b0;
              error    <= 1'b0;
              err_code <= 2'd0;
              cpu_halt <= 1'b1;
            end
          end
          A_LO: if (take) begin
            mem_addr[7:0] <= rx_data;
            csum          <= csum + rx_data;
            state         <= A_HI;
          end
          A_HI: if (take) begin
            mem_addr[ADDR_W-1:8] <= rx_data[ADDR_W-9:0];
            csum                 <= csum + rx_data;
            state                <= C_LO;
          end
          C_LO: if (take) begin
            cnt_lo <= rx_data;
            csum   <= csum + rx_data;
            state  <= C_HI;
          end
          C_HI: if (take) begin
            words_left <= {rx_data, cnt_lo};
            byte_idx   <= 2'd0;
            csum       <= csum + rx_data;
            state      <= ({rx_data, cnt_lo} == 16'd0) ? CSUM : DATA;
          end
          DATA: if (take) begin
            csum      <= csum + rx_data;
            asm_bytes <= {rx_data, asm_bytes[23:8]};
            byte_idx  <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              // Upper bits of the 32-bit little-endian word are dropped.
              mem_wdata <= DATA_W'({rx_data, asm_bytes});
              mem_we    <= 1'b1;
              rx_ready  <= 1'b0;
              ov_cnt    <= 9'd0;
              state     <= WRITE;
            end
          end
          WRITE: begin
            if (mem_ready) begin
              mem_we     <= 1'b0;
              mem_addr   <= mem_addr + ADDR_W'(1);
              words_left <= words_left - 16'd1;
              state      <= (words_left == 16'd1) ? CSUM : DATA;
            end else if (rx_valid && ov_cnt == OVERLAP_LIMIT) begin
              // Host kept pushing while memory stalled: give up on the frame.
              mem_we   <= 1'b0;
              error    <= 1'b1;
              err_code <= ERR_OVERLAP;
              cpu_halt <= 1'b0;
              state    <= IDLE;
            end else begin
              rx_ready <= 1'b0;
              if (rx_valid) ov_cnt <= ov_cnt + 9'd1;
            end
          end
          CSUM: if (take) begin
            if (rx_data == csum) begin
              done <= 1'b1;
            end else begin
              error    <= 1'b1;
              err_code <= ERR_CSUM;
            end
            cpu_halt <= 1'b0;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: randomized frame-level bench for mem_loader.
//
// Frames are built from word lists; the expected memory writes and the
// expected checksum are computed arithmetically when a frame is built. A
// negedge process compares status outputs against the frame-level model on
// every cycle and matches each completed write against the expected queue.
module tb_mem_loader;

  localparam int TO = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [14:0] mem_addr;
  logic [25:0] mem_wdata;
  logic        mem_we;
  logic        mem_ready;
  logic        cpu_halt;
  logic        done;
  logic        error;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  mem_loader dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .cpu_halt  (cpu_halt),
    .done      (done),
    .error     (error),
    .err_code  (err_code)
  );

  typedef struct packed {
    logic [14:0] addr;
    logic [25:0] data;
  } wr_t;

  wr_t         sb[$];     // expected writes, oldest first
  logic [7:0]  bq[$];     // bytes of the frame being sent
  logic [31:0] wq[$];     // words of the frame being built
  logic [7:0]  last_csum;

  int n_tests = 0;
  int n_fail  = 0;
  int n_writes = 0;

  logic       exp_done  = 1'b0;
  logic       exp_error = 1'b0;
  logic       exp_halt  = 1'b0;
  logic [1:0] exp_code  = 2'd0;
  bit         chk_en    = 1'b0;
  int         ready_mode = 0;   // 0 random, 1 held low, 2 held high

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory acceptance, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       mem_ready = 1'b0;
      2:       mem_ready = 1'b1;
      default: mem_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // Per-cycle compare and write scoreboard.
  logic        prev_we = 1'b0;
  logic [14:0] prev_addr;
  logic [25:0] prev_data;
  always @(negedge clk) begin
    if (chk_en) begin
      check("done", done, exp_done);
      check("error", error, exp_error);
      check("err_code", err_code, exp_code);
      check("cpu_halt", cpu_halt, exp_halt);
      check("rx_ready_vs_we", rx_ready, !mem_we);
      if (mem_we && prev_we) begin
        check("addr_stable", mem_addr, prev_addr);
        check("wdata_stable", mem_wdata, prev_data);
      end
    end
    if (mem_we && mem_ready && !rst) begin
      n_writes++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_write: addr %0h data %0h with no write expected", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("write_addr", mem_addr, e.addr);
        check("write_data", mem_wdata, e.data);
      end
    end
    prev_we   = mem_we;
    prev_addr = mem_addr;
    prev_data = mem_wdata;
  end

  // Build a frame from wq; expected writes go to sb, checksum to last_csum.
  task automatic build_frame(input logic [14:0] addr, input bit bad, input bit hi7);
    logic [7:0]  s;
    logic [15:0] n;
    n = 16'(wq.size());
    bq.delete();
    bq.push_back(8'hA5);
    bq.push_back(addr[7:0]);
    bq.push_back({hi7, addr[14:8]});
    bq.push_back(n[7:0]);
    bq.push_back(n[15:8]);
    for (int i = 0; i < wq.size(); i++) begin
      bq.push_back(wq[i][7:0]);
      bq.push_back(wq[i][15:8]);
      bq.push_back(wq[i][23:16]);
      bq.push_back(wq[i][31:24]);
      sb.push_back({15'(addr + 15'(i)), wq[i][25:0]});
    end
    s = 8'd0;
    for (int i = 1; i < bq.size(); i++) s = s + bq[i];
    last_csum = s;
    bq.push_back(bad ? (s ^ 8'h01) : s);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL send_byte: byte %0h never accepted", b);
    rx_valid = 1'b0;
  endtask

  // Send bq[first..last], updating the frame-level model as bytes land.
  task automatic send_frame(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      send_byte(bq[i]);
      if (i == 0) begin
        exp_halt  = 1'b1;
        exp_done  = 1'b0;
        exp_error = 1'b0;
        exp_code  = 2'd0;
      end else if (i == bq.size() - 1) begin
        exp_halt = 1'b0;
        if (bq[i] == last_csum) exp_done = 1'b1;
        else begin
          exp_error = 1'b1;
          exp_code  = 2'd1;
        end
        check("queue_drained", sb.size(), 0);
      end else if (i >= 5 && (i - 5) % 4 == 3) begin
        check("we_latency", mem_we, 1'b1);
        check("wdata_at_we", mem_wdata, sb[0].data);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_ready"}, rx_ready, 1'b0);
    check({tag, "_mem_addr"}, mem_addr, 15'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 26'h0);
    check({tag, "_mem_we"}, mem_we, 1'b0);
    check({tag, "_cpu_halt"}, cpu_halt, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_error"}, error, 1'b0);
    check({tag, "_err_code"}, err_code, 2'd0);
  endtask

  initial begin
    #500000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int          wr_before;
    int          n;
    logic [14:0] a;
    logic [7:0]  g;

    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Reference frame with hand-computed checksum and writes.
    wq = '{32'h03FFFFFF, 32'h00000123};
    build_frame(15'h0100, 1'b0, 1'b0);
    check("pin_csum", last_csum, 8'h27);
    check("pin_w0", sb[0], {15'h0100, 26'h3FFFFFF});
    check("pin_w1", sb[1], {15'h0101, 26'h0000123});
    send_frame(0, bq.size() - 1);
    check("ref_done", done, 1'b1);
    check("ref_halt", cpu_halt, 1'b0);

    // Upper word bits dropped.
    wq = '{32'hFFFFFFFF};
    build_frame(15'h0010, 1'b0, 1'b1);
    check("pin_trunc", sb[0].data, 26'h3FFFFFF);
    send_frame(0, bq.size() - 1);

    // Address wrap.
    wq = '{32'h00000011, 32'h00000022};
    build_frame(15'h7FFF, 1'b0, 1'b0);
    check("pin_wrap0", sb[0].addr, 15'h7FFF);
    check("pin_wrap1", sb[1].addr, 15'h0000);
    send_frame(0, bq.size() - 1);

    // Memory stall: write held with stable address/data.
    ready_mode = 1;
    wq = '{32'h0155AA33};
    build_frame(15'h1234, 1'b0, 1'b0);
    wr_before = n_writes;
    send_frame(0, 8);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_we", mem_we, 1'b1);
      check("stall_rx_ready", rx_ready, 1'b0);
      check("stall_addr", mem_addr, 15'h1234);
      check("stall_data", mem_wdata, 26'h155AA33);
    end
    ready_mode = 0;
    send_frame(9, 9);
    check("stall_one_write", n_writes, wr_before + 1);

    // Bad checksum then a good frame.
    wq = '{32'h00C0FFEE};
    build_frame(15'h0400, 1'b1, 1'b0);
    send_frame(0, bq.size() - 1);
    check("bad_error", error, 1'b1);
    check("bad_code", err_code, 2'd1);
    check("bad_done", done, 1'b0);
    wq = '{32'h00000555};
    build_frame(15'h0401, 1'b0, 1'b0);
    send_frame(0, bq.size() - 1);
    check("recover_done", done, 1'b1);
    check("recover_error", error, 1'b0);

    // Inter-byte timeout after ADDR_HI.
    wq.delete();
    build_frame(15'h0042, 1'b0, 1'b0);
    send_frame(0, 2);
    repeat (TO - 1) @(posedge clk);
    #1;
    check("to_early_halt", cpu_halt, 1'b1);
    check("to_early_error", error, 1'b0);
    @(posedge clk);
    #1;
    exp_halt  = 1'b0;
    exp_error = 1'b1;
    exp_code  = 2'd2;
    check("to_error", error, 1'b1);
    check("to_code", err_code, 2'd2);
    check("to_halt", cpu_halt, 1'b0);
    check("to_idle_ready", rx_ready, 1'b1);

    // Write overlap: host keeps a byte pending while memory never accepts.
    ready_mode = 1;
    wq = '{32'h12345678};
    build_frame(15'h0200, 1'b0, 1'b0);
    wr_before = n_writes;
    send_frame(0, 8);
    chk_en   = 1'b0;
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    repeat (250) @(posedge clk);
    #1;
    check("ov_still_writing", mem_we, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check("ov_we", mem_we, 1'b0);
    check("ov_error", error, 1'b1);
    check("ov_code", err_code, 2'd3);
    check("ov_halt", cpu_halt, 1'b0);
    check("ov_no_write", n_writes, wr_before);
    sb.delete();
    exp_halt   = 1'b0;
    exp_error  = 1'b1;
    exp_code   = 2'd3;
    exp_done   = 1'b0;
    ready_mode = 0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Randomized frames, some with garbage in front and bad checksums.
    for (int f = 0; f < 12; f++) begin
      n = $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0) a = 15'(15'h7FFE + 15'($urandom_range(0, 1)));
      else                           a = 15'($urandom);
      wq.delete();
      for (int k = 0; k < n; k++) wq.push_back($urandom);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) begin
          do g = 8'($urandom); while (g == 8'hA5);
          send_byte(g);
        end
      end
      build_frame(a, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      send_frame(0, bq.size() - 1);
    end

    // Reset in the middle of DATA, then garbage before a fresh frame.
    wq = '{32'hDEADBEEF};
    build_frame(15'h0300, 1'b0, 1'b0);
    send_frame(0, 6);
    chk_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    sb.delete();
    exp_done  = 1'b0;
    exp_error = 1'b0;
    exp_code  = 2'd0;
    exp_halt  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    send_byte(8'h00);
    send_byte(8'h11);
    check("garbage_no_halt", cpu_halt, 1'b0);
    wq = '{32'h00ABCDEF};
    build_frame(15'h0300, 1'b0, 1'b0);
    send_frame(0, bq.size() - 1);
    check("post_rst_done", done, 1'b1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
